// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and types for the IF-stage fetch queue: datapath width,
// the NOP encoding and the IF/ID bundle layout.
package if_fetch_queue_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam int IFID_W = 3 * DEF_DATA_WIDTH;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] instr;
        logic [DEF_DATA_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0] pc_plus4;
    } if_id_t;

    // Occupancy counters need one extra bit so "full" (== depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Instruction-memory request/response and IF/ID handshake bundle.
// master = fetch queue side, slave = memory / decode side.
interface if_fetch_queue_if
    import if_fetch_queue_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  id_ready;
    logic                  id_valid;
    logic [DATA_WIDTH-1:0] id_instr;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [DATA_WIDTH-1:0] id_pc_plus4;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  id_ready,
        output id_valid, id_instr, id_pc, id_pc_plus4
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output id_ready,
        input  id_valid, id_instr, id_pc, id_pc_plus4
    );

endinterface

// File: rtl/if_fetch_queue_fifo.sv
// Parameterised synchronous FIFO with flush; head entry is visible
// combinationally so a pushed word is presented the cycle after its write.
module if_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [DEPTH-1:0] wr_sel;
    logic             push_eff;
    logic             pop_eff;

    // Flush wins over both ports in the same cycle.
    assign push_eff = push && !flush;
    assign pop_eff  = pop && !flush && !empty;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push_eff && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= wr_ptr_reg;
            count_reg  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            unique case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count     = count_reg;
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign head_data = mem[rd_ptr_reg];

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count_reg <= CNT_W'(DEPTH));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
        !(pop && !flush && empty));

endmodule

// File: rtl/if_fetch_queue.sv
// IF-stage fetch queue: issues credit-limited fetches at pc_i, buffers the
// returned words with their PC and presents {instr, pc, pc+4} to decode.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  flush,
    output logic                  pc_advance,
    output logic [CNT_W-1:0]      count,
    if_fetch_queue_if.master      bus
);

    logic                    issue;
    logic                    inflight_reg;
    logic                    discard_reg;
    logic [DATA_WIDTH-1:0]   req_pc_reg;
    logic [CNT_W:0]          committed;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [2*DATA_WIDTH-1:0] head_data;
    logic [DATA_WIDTH-1:0]   head_instr;
    logic [DATA_WIDTH-1:0]   head_pc;

    // Credit counts the in-flight word as occupied; a same-cycle pop is
    // deliberately ignored so id_ready never reaches imem_req combinationally.
    assign committed = {1'b0, count} + (CNT_W+1)'(inflight_reg);
    assign issue     = !reset && !flush && (committed < (CNT_W+1)'(DEPTH));

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_i;
    assign pc_advance    = issue;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_reg <= 1'b0;
            discard_reg  <= 1'b0;
            req_pc_reg   <= '0;
        end else begin
            inflight_reg <= issue;
            discard_reg  <= flush;
            if (issue) begin
                req_pc_reg <= pc_i;
            end
        end
    end

    assign push = inflight_reg && !discard_reg && !flush;
    assign pop  = bus.id_valid && bus.id_ready;

    if_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({bus.imem_rdata, req_pc_reg}),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .head_data (head_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign head_instr = head_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign head_pc    = head_data[DATA_WIDTH-1:0];

    // Memory contents are not reset, so the head is masked while empty.
    assign bus.id_valid    = !fifo_empty;
    assign bus.id_instr    = bus.id_valid ? head_instr : DATA_WIDTH'(INSTR_NOP);
    assign bus.id_pc       = bus.id_valid ? head_pc : '0;
    assign bus.id_pc_plus4 = bus.id_valid ? (head_pc + DATA_WIDTH'(4)) : '0;

    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: per-cycle vector table plus a
// scoreboard of fetched words compared on every decode pop.
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam int DW    = DEF_DATA_WIDTH;
    localparam int DEPTH = 4;
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int CW    = IFID_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic [DW-1:0]    pc_i = '0;
    logic             pc_advance;
    logic [CNT_W-1:0] count;

    if_fetch_queue_if #(.DATA_WIDTH(DW)) bus ();

    if_fetch_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_i       (pc_i),
        .flush      (flush),
        .pc_advance (pc_advance),
        .count      (count),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        rdy;
        logic [31:0] tgt;
        logic        exp_req;
        logic        exp_valid;
        int          exp_count;
        logic [31:0] exp_pc;
        logic [31:0] exp_id_pc;
    } vec_t;

    vec_t   vecs[$];
    if_id_t sb[$];
    int     n_vec = 0;
    int     n_err = 0;

    logic [31:0]      pc_model = '0;
    logic             s_req, s_adv, s_valid;
    logic [31:0]      s_addr, s_pc, s_instr, s_id_pc, s_id_pc4;
    logic [CNT_W-1:0] s_count;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h2008_0005 + (a >> 2) * 32'h0001_0002;
    endfunction

    task automatic check(input string name, input int row,
                         input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h, want %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic rdy, input logic [31:0] tgt,
                       input logic req, input logic v, input int cnt,
                       input logic [31:0] pc, input logic [31:0] idpc);
        vec_t e;
        e.rst = r; e.flush = f; e.rdy = rdy; e.tgt = tgt;
        e.exp_req = req; e.exp_valid = v; e.exp_count = cnt;
        e.exp_pc = pc; e.exp_id_pc = idpc;
        vecs.push_back(e);
    endtask

    // One clock cycle: drive at negedge, sample 2 units later, advance PC
    // and memory models after the following posedge.
    task automatic cycle(input int row, input logic r, input logic f,
                         input logic rdy, input logic [31:0] tgt);
        if_id_t e;
        reset = r; flush = f; bus.id_ready = rdy;
        if (r) begin
            pc_model = '0;
            sb.delete();
        end
        pc_i = pc_model;
        #2;
        s_req = bus.imem_req;   s_adv = pc_advance;   s_addr = bus.imem_addr;
        s_valid = bus.id_valid; s_count = count;      s_pc = pc_model;
        s_instr = bus.id_instr; s_id_pc = bus.id_pc;  s_id_pc4 = bus.id_pc_plus4;
        if (f) begin
            sb.delete();
        end else if (s_valid && rdy) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL pop row %0d: got id_pc %h, want no entry", row, s_id_pc);
            end else begin
                e = sb.pop_front();
                check("pop_bundle", row, CW'({s_instr, s_id_pc, s_id_pc4}), CW'(e));
            end
        end
        if (s_req) begin
            check("imem_addr", row, CW'(s_addr), CW'(pc_model));
            e.instr = word(pc_model); e.pc = pc_model; e.pc_plus4 = pc_model + 32'd4;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (r)          pc_model = '0;
        else if (f)     pc_model = tgt;
        else if (s_adv) pc_model = pc_model + 32'd4;
        bus.imem_rdata = s_req ? word(s_addr) : 32'hDEAD_BEEF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        // Streaming from reset with decode always ready.
        add(1,0,1,0, 0,0,0,32'h00,32'h00);
        add(0,0,1,0, 1,0,0,32'h00,32'h00);
        add(0,0,1,0, 1,0,0,32'h04,32'h00);
        add(0,0,1,0, 1,1,1,32'h08,32'h00);
        add(0,0,1,0, 1,1,1,32'h0C,32'h04);
        add(0,0,1,0, 1,1,1,32'h10,32'h08);
        // Decode stalled: fill to DEPTH, PC freezes at 0x10, then drain.
        add(1,0,0,0, 0,0,0,32'h00,32'h00);
        add(0,0,0,0, 1,0,0,32'h00,32'h00);
        add(0,0,0,0, 1,0,0,32'h04,32'h00);
        add(0,0,0,0, 1,1,1,32'h08,32'h00);
        add(0,0,0,0, 1,1,2,32'h0C,32'h00);
        add(0,0,0,0, 0,1,3,32'h10,32'h00);
        add(0,0,0,0, 0,1,4,32'h10,32'h00);
        add(0,0,1,0, 0,1,4,32'h10,32'h00);
        add(0,0,1,0, 1,1,3,32'h10,32'h04);
        add(0,0,1,0, 1,1,2,32'h14,32'h08);
        add(0,0,1,0, 1,1,2,32'h18,32'h0C);
        add(0,0,1,0, 1,1,2,32'h1C,32'h10);
        // Flush with count=3 and 0x0C in flight, target 0x40.
        add(1,0,0,0, 0,0,0,32'h00,32'h00);
        add(0,0,0,0, 1,0,0,32'h00,32'h00);
        add(0,0,0,0, 1,0,0,32'h04,32'h00);
        add(0,0,0,0, 1,1,1,32'h08,32'h00);
        add(0,0,0,0, 1,1,2,32'h0C,32'h00);
        add(0,1,0,32'h40, 0,1,3,32'h10,32'h00);
        add(0,0,1,0, 1,0,0,32'h40,32'h00);
        add(0,0,1,0, 1,0,0,32'h44,32'h00);
        add(0,0,1,0, 1,1,1,32'h48,32'h40);
        add(0,0,1,0, 1,1,1,32'h4C,32'h44);
        // Flush with a pop request and a response arriving together.
        add(0,1,1,32'h80, 0,1,1,32'h50,32'h48);
        add(0,0,1,0, 1,0,0,32'h80,32'h00);
        add(0,0,1,0, 1,0,0,32'h84,32'h00);
        add(0,0,1,0, 1,1,1,32'h88,32'h80);
        // Redirect to the top of the address space: pc+4 wraps to 0.
        add(0,1,1,32'hFFFF_FFFC, 0,1,1,32'h8C,32'h84);
        add(0,0,1,0, 1,0,0,32'hFFFF_FFFC,32'h00);
        add(0,0,1,0, 1,0,0,32'h00,32'h00);
        add(0,0,1,0, 1,1,1,32'h04,32'hFFFF_FFFC);
        add(0,0,1,0, 1,1,1,32'h08,32'h00);

        bus.id_ready   = 1'b0;
        bus.imem_rdata = '0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            cycle(i, v.rst, v.flush, v.rdy, v.tgt);
            check("imem_req", i, CW'(s_req), CW'(v.exp_req));
            check("pc_advance", i, CW'(s_adv), CW'(v.exp_req));
            check("id_valid", i, CW'(s_valid), CW'(v.exp_valid));
            check("count", i, CW'(s_count), CW'(v.exp_count));
            check("pc", i, CW'(s_pc), CW'(v.exp_pc));
            check("id_pc", i, CW'(s_id_pc), CW'(v.exp_id_pc));
            if (!v.exp_valid) begin
                check("id_instr_idle", i, CW'(s_instr), CW'(0));
                check("id_pc4_idle", i, CW'(s_id_pc4), CW'(0));
            end
        end

        // Asynchronous reset asserted mid-cycle while two entries are held.
        cycle(100, 0, 0, 0, 0);
        check("hs_count1", 100, CW'(s_count), CW'(1));
        reset = 1'b0; flush = 1'b0; bus.id_ready = 1'b0; pc_i = pc_model;
        #2;
        check("hs_count2", 101, CW'(count), CW'(2));
        check("hs_valid", 101, CW'(bus.id_valid), CW'(1));
        #1 reset = 1'b1;
        #1;
        check("arst_count", 101, CW'(count), CW'(0));
        check("arst_valid", 101, CW'(bus.id_valid), CW'(0));
        check("arst_instr", 101, CW'(bus.id_instr), CW'(0));
        check("arst_id_pc", 101, CW'(bus.id_pc), CW'(0));
        check("arst_pc4", 101, CW'(bus.id_pc_plus4), CW'(0));
        check("arst_req", 101, CW'(bus.imem_req), CW'(0));
        check("arst_adv", 101, CW'(pc_advance), CW'(0));
        @(posedge clk);
        @(negedge clk);
        pc_model = '0;
        sb.delete();
        bus.imem_rdata = 32'hDEAD_BEEF;

        cycle(102, 0, 0, 1, 0);
        check("restart_req", 102, CW'(s_req), CW'(1));
        check("restart_addr", 102, CW'(s_addr), CW'(0));
        cycle(103, 0, 0, 1, 0);
        check("restart_lat", 103, CW'(s_valid), CW'(0));
        cycle(104, 0, 0, 1, 0);
        check("restart_valid", 104, CW'(s_valid), CW'(1));
        check("restart_id_pc", 104, CW'(s_id_pc), CW'(0));
        cycle(105, 0, 0, 1, 0);
        check("restart_next", 105, CW'(s_id_pc), CW'(4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
